// File: rtl/pid_output_limiter.sv
// PID output conditioning: arithmetic scale, clamp, slew limit, saturation status and counter.
// Latency 3 cycles, one sample per clock; there is no backpressure, so every valid input produces an update slot.
module pid_output_limiter #(
    parameter int IN_WIDTH    = 29,
    parameter int OUT_WIDTH   = 14,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IN_WIDTH-1:0]    din,
    input  logic                   din_valid,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [OUT_WIDTH-1:0]   upper_limit,
    input  logic [OUT_WIDTH-1:0]   lower_limit,
    input  logic [OUT_WIDTH-1:0]   max_step,
    input  logic                   hold,
    input  logic                   clear_count,
    output logic [OUT_WIDTH-1:0]   dout,
    output logic                   dout_valid,
    output logic                   sat_high,
    output logic                   sat_low,
    output logic [31:0]            sat_count
);
    localparam int MAX_SHIFT = IN_WIDTH - 1;
    localparam int DW        = OUT_WIDTH + 1;

    logic [SHIFT_WIDTH-1:0] shift_eff;
    logic [IN_WIDTH-1:0]    s1;
    logic                   s1_valid;

    logic [IN_WIDTH-1:0]    upper_ext;
    logic [IN_WIDTH-1:0]    lower_ext;
    logic [IN_WIDTH-1:0]    upper_cut;
    logic                   hi_flag;
    logic                   lo_flag;
    logic [OUT_WIDTH-1:0]   target_c;

    logic [OUT_WIDTH-1:0]   target;
    logic                   s2_valid;
    logic                   s2_hi;
    logic                   s2_lo;

    logic [DW-1:0]          delta;
    logic [DW-1:0]          delta_mag;
    logic [OUT_WIDTH-1:0]   dout_next;

    // Stage 1: scale
    always_comb begin
        shift_eff = (int'(shift) > MAX_SHIFT) ? SHIFT_WIDTH'(MAX_SHIFT) : shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= din_valid;
            s1       <= $signed(din) >>> shift_eff;
        end
    end

    // Stage 2: clamp; the lower limit is applied last so it wins when limits cross
    always_comb begin
        upper_ext = IN_WIDTH'($signed(upper_limit));
        lower_ext = IN_WIDTH'($signed(lower_limit));
        hi_flag   = $signed(s1) > $signed(upper_ext);
        upper_cut = hi_flag ? upper_ext : s1;
        lo_flag   = $signed(upper_cut) < $signed(lower_ext);
        target_c  = lo_flag ? lower_limit : (hi_flag ? upper_limit : s1[OUT_WIDTH-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_hi    <= 1'b0;
            s2_lo    <= 1'b0;
            target   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_hi    <= hi_flag;
            s2_lo    <= lo_flag;
            target   <= target_c;
        end
    end

    // Stage 3: slew limit; dout only ever steps toward an in-range target, so the narrow add cannot wrap
    always_comb begin
        delta     = {target[OUT_WIDTH-1], target} - {dout[OUT_WIDTH-1], dout};
        delta_mag = delta[DW-1] ? -delta : delta;
        if (max_step == '0 || delta_mag <= {1'b0, max_step}) begin
            dout_next = target;
        end else if (!delta[DW-1]) begin
            dout_next = dout + max_step;
        end else begin
            dout_next = dout - max_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            sat_high   <= 1'b0;
            sat_low    <= 1'b0;
            sat_count  <= '0;
        end else begin
            dout_valid <= s2_valid;
            if (s2_valid) begin
                sat_high <= s2_hi;
                sat_low  <= s2_lo;
                if (!hold) begin
                    dout <= dout_next;
                end
            end
            if (clear_count) begin
                sat_count <= '0;
            end else if (s2_valid && (s2_hi || s2_lo) && sat_count != '1) begin
                sat_count <= sat_count + 32'd1;
            end
        end
    end
endmodule
